// File: rtl/neander_x_seq_alu.sv
// NEANDER-X sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete in this state
// CALC  | MUL/DIV iterating, one step per clock, busy held high
module neander_x_seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_high,
   output logic             carry_out,
   output logic             zero,
   output logic             negative,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_NEG = 4'h8;
   localparam logic [3:0] OP_MUL = 4'h9;
   localparam logic [3:0] OP_DIV = 4'hA;
   localparam logic [3:0] OP_SAR = 4'hB;
   localparam logic [3:0] OP_ROL = 4'hC;
   localparam logic [3:0] OP_ROR = 4'hD;

   typedef enum logic {IDLE, CALC} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic [WIDTH-1:0] p_hi, p_lo, mcand;
   logic [WIDTH-1:0] it_hi, it_lo;
   logic [WIDTH-1:0] sc_res, sc_hi;
   logic             sc_cy;
   logic             launch_iter;
   logic             last_step;

   logic [WIDTH:0]   add_ext, sub_ext, mul_sum, div_shift, div_trial;

   assign add_ext     = {1'b0, a} + {1'b0, b};
   assign sub_ext     = {1'b0, a} - {1'b0, b};
   assign launch_iter = start && ((alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b != '0)));
   assign last_step   = (cnt == CW'(1));

   // One multiply step adds the multiplicand when the multiplier LSB is set,
   // then shifts the product pair right; the divide step is restoring.
   assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
   assign div_shift = {p_hi, p_lo[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, mcand};

   // Next partial product / remainder-quotient pair.
   always_comb begin
      it_hi = '0;
      it_lo = '0;
      if (is_div) begin
         it_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
         it_lo = {p_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
         it_hi = mul_sum[WIDTH:1];
         it_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
      end
   end

   // Single-cycle result and flag; DIV here only covers divide-by-zero.
   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_cy  = 1'b0;
      case (alu_op)
         OP_ADD: begin sc_res = add_ext[WIDTH-1:0]; sc_cy = add_ext[WIDTH]; end
         OP_SUB: begin sc_res = sub_ext[WIDTH-1:0]; sc_cy = sub_ext[WIDTH]; end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         OP_NOT: sc_res = ~a;
         OP_SHL: begin sc_res = {a[WIDTH-2:0], 1'b0};        sc_cy = a[WIDTH-1]; end
         OP_SHR: begin sc_res = {1'b0, a[WIDTH-1:1]};        sc_cy = a[0];       end
         OP_NEG: begin sc_res = WIDTH'(0) - a;               sc_cy = |a;         end
         OP_DIV: begin sc_res = '1; sc_hi = a;               sc_cy = 1'b1;       end
         OP_SAR: begin sc_res = {a[WIDTH-1], a[WIDTH-1:1]};  sc_cy = a[0];       end
         OP_ROL: begin sc_res = {a[WIDTH-2:0], a[WIDTH-1]};  sc_cy = a[WIDTH-1]; end
         OP_ROR: begin sc_res = {a[0], a[WIDTH-1:1]};        sc_cy = a[0];       end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (launch_iter) state_next = CALC;
         CALC: if (last_step)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath, iteration counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         result      <= '0;
         result_high <= '0;
         carry_out   <= 1'b0;
         zero        <= 1'b0;
         negative    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cnt         <= '0;
         is_div      <= 1'b0;
         p_hi        <= '0;
         p_lo        <= '0;
         mcand       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (launch_iter) begin
                  p_hi   <= '0;
                  p_lo   <= a;
                  mcand  <= b;
                  is_div <= (alu_op == OP_DIV);
                  cnt    <= CW'(WIDTH);
                  busy   <= 1'b1;
               end else if (start) begin
                  result      <= sc_res;
                  result_high <= sc_hi;
                  carry_out   <= sc_cy;
                  zero        <= (sc_res == '0);
                  negative    <= sc_res[WIDTH-1];
                  done        <= 1'b1;
               end
            end
            CALC: begin
               p_hi <= it_hi;
               p_lo <= it_lo;
               cnt  <= cnt - CW'(1);
               if (last_step) begin
                  // it_lo is the low product or the quotient; it_hi the high
                  // product or the remainder.
                  result      <= it_lo;
                  result_high <= it_hi;
                  carry_out   <= is_div ? 1'b0 : (it_hi != '0);
                  zero        <= (it_lo == '0);
                  negative    <= it_lo[WIDTH-1];
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neander_x_seq_alu.sv
// Directed bench for neander_x_seq_alu at WIDTH=8 and WIDTH=16.
module tb_neander_x_seq_alu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, start16;
   logic [3:0]  alu_op, alu_op16;
   logic [7:0]  a, b, result, result_high;
   logic        carry_out, zero, negative, busy, done;
   logic [15:0] a16, b16, result16, result_high16;
   logic        carry_out16, zero16, negative16, busy16, done16;

   int checks   = 0;
   int failures = 0;

   neander_x_seq_alu #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .a(a), .b(b),
      .result(result), .result_high(result_high), .carry_out(carry_out),
      .zero(zero), .negative(negative), .busy(busy), .done(done)
   );

   neander_x_seq_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .alu_op(alu_op16), .a(a16), .b(b16),
      .result(result16), .result_high(result_high16), .carry_out(carry_out16),
      .zero(zero16), .negative(negative16), .busy(busy16), .done(done16)
   );

   // Present an op for one edge; returns 1 ns after launch edge k.
   task automatic issue(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
      alu_op = op; a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic issue16(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
      alu_op16 = op; a16 = va; b16 = vb; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
   endtask

   // Cycles from launch edge to done, and how many of those samples had busy high.
   task automatic wait_done(output int n, output int bc);
      n = 0; bc = 0;
      while (!done && n < 40) begin
         if (busy) bc++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_done16(output int n);
      n = 0;
      while (!done16 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; start16 = 1'b0;
      alu_op = 4'h0; a = '0; b = '0; alu_op16 = 4'h0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({result, result_high, carry_out, zero, negative, busy, done} !== 21'd0) begin
         failures++;
         $display("FAIL reset_outputs: got res=%h hi=%h c=%b z=%b n=%b busy=%b done=%b, expected all 0",
                  result, result_high, carry_out, zero, negative, busy, done);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      issue(4'h0, 8'hFF, 8'h01);
      checks++;
      if ({done, busy, result, carry_out, zero, negative} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL add_ff_01: got done=%b busy=%b res=%h c=%b z=%b n=%b, expected done=1 busy=0 res=00 c=1 z=1 n=0",
                  done, busy, result, carry_out, zero, negative);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h00) begin
         failures++;
         $display("FAIL add_done_pulse: got done=%b busy=%b res=%h, expected done=0 busy=0 res=00", done, busy, result);
      end
   endtask

   task automatic test_mul;
      int n, bc;
      issue(4'h9, 8'h10, 8'h10);
      wait_done(n, bc);
      checks++;
      if (n !== 8 || bc !== 8 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mul_latency: got cycles=%0d busy_cycles=%0d busy=%b, expected 8 8 0", n, bc, busy);
      end
      checks++;
      if ({result, result_high, carry_out, zero, negative} !== {8'h00, 8'h01, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL mul_10x10: got res=%h hi=%h c=%b z=%b n=%b, expected 00 01 1 1 0",
                  result, result_high, carry_out, zero, negative);
      end
      @(posedge clk); #1;
      issue(4'h9, 8'h0F, 8'h0F);
      wait_done(n, bc);
      checks++;
      if (n !== 8 || {result, result_high, carry_out, zero, negative} !== {8'hE1, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL mul_0fx0f: got cycles=%0d res=%h hi=%h c=%b z=%b n=%b, expected 8 e1 00 0 0 1",
                  n, result, result_high, carry_out, zero, negative);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_div;
      int n, bc;
      issue(4'hA, 8'd200, 8'd7);
      wait_done(n, bc);
      checks++;
      if (n !== 8 || {result, result_high, carry_out, zero, negative} !== {8'h1C, 8'h04, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL div_200_7: got cycles=%0d res=%h hi=%h c=%b z=%b n=%b, expected 8 1c 04 0 0 0",
                  n, result, result_high, carry_out, zero, negative);
      end
      @(posedge clk); #1;
      issue(4'hA, 8'h55, 8'h00);
      checks++;
      if ({done, busy, result, result_high, carry_out, negative} !== {1'b1, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL div_by_zero: got done=%b busy=%b res=%h hi=%h c=%b n=%b, expected 1 0 ff 55 1 1",
                  done, busy, result, result_high, carry_out, negative);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_ops;
      logic [3:0] ops  [12] = '{4'h1, 4'h8, 4'h8, 4'h6, 4'h7, 4'hC, 4'hD, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF};
      logic [7:0] va   [12] = '{8'h05, 8'h01, 8'h00, 8'h81, 8'h81, 8'h81, 8'h02, 8'hF0, 8'hF0, 8'hFF, 8'h0F, 8'hAA};
      logic [7:0] vb   [12] = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h0F, 8'h0F, 8'h00, 8'h55};
      logic [7:0] eres [12] = '{8'hFE, 8'hFF, 8'h00, 8'h02, 8'h40, 8'h03, 8'h01, 8'h30, 8'hFF, 8'hF0, 8'hF0, 8'h00};
      logic       ecy  [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      // start stays high across entries, so each op is accepted in the cycle
      // the previous done is high.
      for (int i = 0; i < 12; i++) begin
         alu_op = ops[i]; a = va[i]; b = vb[i]; start = 1'b1;
         @(posedge clk); #1;
         checks++;
         if ({done, result, result_high, carry_out, zero} !== {1'b1, eres[i], 8'h00, ecy[i], (eres[i] == 8'h00)}) begin
            failures++;
            $display("FAIL single_op_%0d(op=%h): got done=%b res=%h hi=%h c=%b z=%b, expected 1 %h 00 %b %b",
                     i, ops[i], done, result, result_high, carry_out, zero, eres[i], ecy[i], (eres[i] == 8'h00));
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start;
      int c, dcount, first;
      issue(4'h9, 8'h0F, 8'h0F);
      c = 1; dcount = 0; first = -1;
      while (c < 20) begin
         if (c == 2) begin alu_op = 4'h0; a = 8'h01; b = 8'h02; start = 1'b1; end
         if (c == 3) start = 1'b0;
         @(posedge clk); #1;
         c++;
         if (done) begin
            dcount++;
            if (first < 0) first = c - 1;
         end
      end
      checks++;
      if (dcount !== 1 || first !== 8 || result !== 8'hE1 || result_high !== 8'h00) begin
         failures++;
         $display("FAIL ignore_start: got done_pulses=%0d done_edge=k+%0d res=%h hi=%h, expected 1 k+8 e1 00",
                  dcount, first, result, result_high);
      end
   endtask

   task automatic test_back_to_back;
      int n, bc;
      issue(4'h9, 8'h03, 8'h05);
      wait_done(n, bc);
      alu_op = 4'h0; a = 8'h10; b = 8'h20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (n !== 8 || done !== 1'b1 || result !== 8'h30 || carry_out !== 1'b0) begin
         failures++;
         $display("FAIL back_to_back: got mul_cycles=%0d done=%b res=%h c=%b, expected 8 1 30 0", n, done, result, carry_out);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_div;
      int dcount;
      issue(4'hA, 8'd200, 8'd7);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({result, result_high, carry_out, zero, negative, busy, done} !== 21'd0) begin
         failures++;
         $display("FAIL reset_mid_div: got res=%h hi=%h c=%b z=%b n=%b busy=%b done=%b, expected all 0",
                  result, result_high, carry_out, zero, negative, busy, done);
      end
      reset = 1'b0;
      dcount = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) dcount++;
      end
      checks++;
      if (dcount !== 0) begin
         failures++;
         $display("FAIL reset_abort: got %0d cycles with done/busy after reset, expected 0", dcount);
      end
      issue(4'hB, 8'h81, 8'h00);
      checks++;
      if ({done, result, carry_out, negative, zero} !== {1'b1, 8'hC0, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sar_81: got done=%b res=%h c=%b n=%b z=%b, expected 1 c0 1 1 0",
                  done, result, carry_out, negative, zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_width16;
      int n;
      issue16(4'h9, 16'hFFFF, 16'hFFFF);
      wait_done16(n);
      checks++;
      if (n !== 16 || {result16, result_high16, carry_out16, zero16} !== {16'h0001, 16'hFFFE, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL mul16: got cycles=%0d res=%h hi=%h c=%b z=%b, expected 16 0001 fffe 1 0",
                  n, result16, result_high16, carry_out16, zero16);
      end
      @(posedge clk); #1;
      issue16(4'hD, 16'h0001, 16'h0000);
      checks++;
      if ({done16, result16, result_high16, carry_out16, negative16} !== {1'b1, 16'h8000, 16'h0000, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL ror16: got done=%b res=%h hi=%h c=%b n=%b, expected 1 8000 0000 1 1",
                  done16, result16, result_high16, carry_out16, negative16);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_add;
      test_mul;
      test_div;
      test_single_ops;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid_div;
      test_width16;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
